// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FPU issue scheduler.
// Holds the reservation slot record, unit index constants, and the default
// latency table and pipelined-unit mask for the add/mul/div/cmp unit set.
package fpu_sched_pkg;

  localparam int SCHED_NUM_UNITS = 4;
  localparam int SCHED_TAG_W     = 5;
  localparam int SCHED_MAX_LAT   = 8;
  localparam int SCHED_UNIT_W    = $clog2(SCHED_NUM_UNITS);

  localparam int UNIT_ADD = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;
  localparam int UNIT_CMP = 3;

  localparam int DEF_UNIT_LAT [SCHED_NUM_UNITS] = '{2, 3, 8, 1};
  localparam logic [SCHED_NUM_UNITS-1:0] DEF_UNIT_PIPE = 4'b1011;

  // One writeback reservation: which unit produces a result and its tag.
  typedef struct packed {
    logic                    valid;
    logic [SCHED_UNIT_W-1:0] unit;
    logic [SCHED_TAG_W-1:0]  tag;
  } slot_t;

  // Width of the in-flight counter for a table of the given depth.
  function automatic int inflight_w(input int max_lat);
    return $clog2(max_lat + 1) + 1;
  endfunction

endpackage

// File: rtl/fpu_resv_table.sv
// Writeback reservation table.
// slot_o[s] holds the op that writes back s cycles from now. The table shifts
// toward slot 0 every clock; an accepted op is written at index acc_idx_i
// (its latency minus one) after the shift. The issue logic guarantees that
// position is free. Reset and flush clear every slot.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        clear all slots at the edge
//   acc_i          insert acc_slot_i at acc_idx_i this edge
//   slot_o         current slot contents
//   inflight_o     registered count of valid slots
module fpu_resv_table
  import fpu_sched_pkg::*;
#(
  parameter int MAX_LAT = SCHED_MAX_LAT,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    acc_i,
  input  logic [IDX_W-1:0]        acc_idx_i,
  input  slot_t                   acc_slot_i,
  output slot_t [MAX_LAT-1:0]     slot_o,
  output logic  [CNT_W-1:0]       inflight_o
);

  slot_t [MAX_LAT-1:0] slot_q, slot_d;
  logic  [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    slot_d = '0;
    for (int s = 0; s < MAX_LAT - 1; s++) begin
      slot_d[s] = slot_q[s+1];
    end
    slot_d[MAX_LAT-1] = '0;
    if (acc_i) begin
      for (int s = 0; s < MAX_LAT; s++) begin
        if (acc_idx_i == IDX_W'(s)) slot_d[s] = acc_slot_i;
      end
    end
    // Counting the next-state slots keeps the count aligned with slot_q.
    cnt_d = '0;
    for (int s = 0; s < MAX_LAT; s++) begin
      cnt_d = cnt_d + CNT_W'(slot_d[s].valid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      slot_q <= '0;
      cnt_q  <= '0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign slot_o     = slot_q;
  assign inflight_o = cnt_q;

endmodule

// File: rtl/fpu_issue_sched.sv
// Issue scheduler for a multi-unit FPU.
// Accepts tagged ops on a valid/ready handshake, fires the selected unit with
// a one-cycle go pulse and reserves the writeback cycle in fpu_resv_table.
// Issue is refused when the writeback cycle is already taken or when an
// iterative unit still has an op in flight. One result per cycle leaves on
// the writeback port, muxed from the producing unit's result bus.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   in_valid_i/in_ready_o   op handshake; in_unit_i, in_tag_i describe the op
//   flush_i                 drop all in-flight ops
//   unit_go_o, unit_res_i   per-unit fire pulse and result bus
//   wb_valid_o, wb_unit_o, wb_tag_o, wb_data_o   writeback port
//   busy_o, inflight_o      occupancy status
module fpu_issue_sched
  import fpu_sched_pkg::*;
#(
  parameter int                   NUM_UNITS = SCHED_NUM_UNITS,
  parameter int                   TAG_W     = SCHED_TAG_W,
  parameter int                   UNIT_LAT [NUM_UNITS] = DEF_UNIT_LAT,
  parameter logic [NUM_UNITS-1:0] UNIT_PIPE = DEF_UNIT_PIPE,
  parameter int                   MAX_LAT   = SCHED_MAX_LAT,
  localparam int                  UNIT_W    = $clog2(NUM_UNITS),
  localparam int                  CNT_W     = $clog2(MAX_LAT + 1) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [UNIT_W-1:0]              in_unit_i,
  input  logic [TAG_W-1:0]               in_tag_i,
  input  logic                           flush_i,
  output logic [NUM_UNITS-1:0]           unit_go_o,
  input  logic [NUM_UNITS-1:0][31:0]     unit_res_i,
  output logic                           wb_valid_o,
  output logic [UNIT_W-1:0]              wb_unit_o,
  output logic [TAG_W-1:0]               wb_tag_o,
  output logic [31:0]                    wb_data_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               inflight_o
);

  localparam int IDX_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // The slot record is shared through the package, so its field widths fix
  // the unit count and tag width.
  if (NUM_UNITS != SCHED_NUM_UNITS || TAG_W != SCHED_TAG_W) begin : g_bad_width
    $error("fpu_issue_sched: NUM_UNITS/TAG_W must match fpu_sched_pkg slot_t");
  end
  if (CNT_W != inflight_w(MAX_LAT)) begin : g_bad_cnt
    $error("fpu_issue_sched: inflight width mismatch");
  end
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lat_chk
    if (UNIT_LAT[i] < 1 || UNIT_LAT[i] > MAX_LAT) begin : g_bad_lat
      $error("fpu_issue_sched: UNIT_LAT out of range 1..MAX_LAT");
    end
  end

  slot_t [MAX_LAT-1:0] slot_q;
  slot_t               acc_slot;
  logic  [NUM_UNITS-1:0] unit_busy;
  logic                unit_ok;
  logic                sel_busy;
  logic                wb_slot_taken;
  logic  [IDX_W-1:0]   acc_idx;
  logic                accept;

  // An iterative unit stays busy until its op has left slot 0.
  always_comb begin
    unit_busy = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      for (int s = 0; s < MAX_LAT; s++) begin
        if (!UNIT_PIPE[i] && slot_q[s].valid && slot_q[s].unit == UNIT_W'(i))
          unit_busy[i] = 1'b1;
      end
    end
  end

  // Slot L (L = latency) shifts into the insertion position L-1 at this
  // edge, so it must be empty. Slot MAX_LAT does not exist and is always free.
  always_comb begin
    unit_ok       = 1'b0;
    sel_busy      = 1'b0;
    wb_slot_taken = 1'b0;
    acc_idx       = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (in_unit_i == UNIT_W'(i)) begin
        unit_ok  = 1'b1;
        sel_busy = unit_busy[i];
        acc_idx  = IDX_W'(UNIT_LAT[i] - 1);
        for (int s = 1; s < MAX_LAT; s++) begin
          if (s == UNIT_LAT[i]) wb_slot_taken = slot_q[s].valid;
        end
      end
    end
  end

  assign in_ready_o = !rst_i && !flush_i && unit_ok && !wb_slot_taken && !sel_busy;
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    unit_go_o = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_go_o[i] = accept && (in_unit_i == UNIT_W'(i));
    end
  end

  always_comb begin
    acc_slot       = '0;
    acc_slot.valid = 1'b1;
    acc_slot.unit  = in_unit_i;
    acc_slot.tag   = in_tag_i;
  end

  fpu_resv_table #(
    .MAX_LAT (MAX_LAT),
    .IDX_W   (IDX_W),
    .CNT_W   (CNT_W)
  ) u_resv (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .acc_i      (accept),
    .acc_idx_i  (acc_idx),
    .acc_slot_i (acc_slot),
    .slot_o     (slot_q),
    .inflight_o (inflight_o)
  );

  // Writeback straight from slot 0; zeroed when idle or held in reset.
  always_comb begin
    wb_valid_o = slot_q[0].valid && !rst_i;
    wb_unit_o  = '0;
    wb_tag_o   = '0;
    wb_data_o  = '0;
    if (wb_valid_o) begin
      wb_unit_o = slot_q[0].unit;
      wb_tag_o  = slot_q[0].tag;
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (slot_q[0].unit == UNIT_W'(i)) wb_data_o = unit_res_i[i];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int s = 0; s < MAX_LAT; s++) begin
      busy_o = busy_o | slot_q[s].valid;
    end
  end

endmodule

// File: doc/fpu_issue_sched.md
Name: fpu_issue_sched

Overview:
- Issue scheduler for a multi-unit FPU; successor to the single-op go/valid FPU top.
- Accepts tagged FP ops on a valid/ready handshake and fires the selected execution unit.
- Tracks every in-flight op in a writeback reservation shift register, so several ops of differing fixed latency overlap.
- Presents exactly one result per cycle on a single writeback port; blocks issue that would collide on writeback or hit a busy non-pipelined unit.

Parameters:
- NUM_UNITS, 4, number of execution units.
- TAG_W, 5, width of op tag.
- UNIT_LAT, '{2,3,8,1}, per-unit fixed latency in cycles (add, mul, div, cmp); each value 1..MAX_LAT.
- UNIT_PIPE, 4'b1011, bit i = 1 means unit i is fully pipelined; 0 means iterative (one op at a time).
- MAX_LAT, 8, depth of reservation table; must be >= max(UNIT_LAT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  op offered.
- in_ready  out  1  op accepted this cycle when in_valid & in_ready.
- in_unit  in  $clog2(NUM_UNITS)  target unit index.
- in_tag  in  TAG_W  op tag, returned on writeback.
- flush  in  1  drop all in-flight ops.
- unit_go  out  NUM_UNITS  one-hot fire pulse to the execution units.
- unit_res  in  NUM_UNITS x 32  unit result buses.
- wb_valid  out  1  result valid this cycle.
- wb_unit  out  $clog2(NUM_UNITS)  producing unit.
- wb_tag  out  TAG_W  tag of result.
- wb_data  out  32  unit_res[wb_unit].
- busy  out  1  any op in flight (any slot 0..MAX_LAT-1 valid).
- inflight  out  $clog2(MAX_LAT+1)+1  count of valid slots.

Behaviour:
- Slot array slot[0..MAX_LAT-1], each {valid, unit, tag}; index = cycles remaining to writeback. slot[MAX_LAT] is constant-empty.
- Every edge: slot[s] <= slot[s+1]. On accept, slot[UNIT_LAT[in_unit]-1] <= {1, in_unit, in_tag}. The accept write never overlaps a shifted-in valid entry, because of the check below.
- Writeback is combinational from slot[0]:
  - wb_valid = slot[0].valid; wb_unit and wb_tag from slot[0].
  - wb_data = unit_res[slot[0].unit].
  - When invalid, wb_unit, wb_tag and wb_data are driven to 0.
- Latency: op accepted at cycle t yields wb_valid at cycle t+UNIT_LAT[in_unit].
- in_ready = !rst & !flush & !slot[L].valid & !unit_busy[in_unit], where L = UNIT_LAT[in_unit].
  - in_ready may depend combinationally on in_unit.
  - in_ready must not depend on in_valid.
- unit_busy[i]: 1 iff UNIT_PIPE[i]==0 and any slot 0..MAX_LAT-1 holds unit i. An iterative unit is re-issuable from the cycle after its writeback.
- unit_go[i] = in_valid & in_ready & (in_unit==i). Pulse of exactly one cycle per accept.
- inflight counts slot valid bits and is registered alongside the slots. Simultaneous accept and writeback in one cycle leaves it unchanged.
- flush:
  - All slots are cleared at the edge; wb_valid is still driven from slot[0] in the flush cycle itself.
  - in_ready is 0 during flush.
  - Results later returned by units are ignored.
- rst:
  - All slots invalid, inflight=0, busy=0.
  - in_ready=0, unit_go=0, wb_valid=0, wb_unit/wb_tag/wb_data=0.
  - Reset mid-operation drops pending ops; no writeback is produced for them.
- in_unit >= NUM_UNITS: in_ready=0.
- Elaboration error if any UNIT_LAT > MAX_LAT or UNIT_LAT == 0.

Decomposition:
- Package fpu_sched_pkg holds:
  - slot_t struct {valid, unit, tag}.
  - Unit index constants UNIT_ADD=0, UNIT_MUL=1, UNIT_DIV=2, UNIT_CMP=3.
  - Default latency table and pipelined mask.
- Sub-module fpu_resv_table: slot shift register, accept insertion, flush/reset, and popcount for inflight. The top holds the ready logic, go decode and writeback mux.

Test Plan:
- Basic latency: add tag 3 at cycle 0, unit_res[0]=32'h3f800000 → unit_go=4'b0001 at cycle 0; wb_valid at cycle 2 with wb_tag=3, wb_unit=0, wb_data=32'h3f800000.
- Writeback collision: mul tag 1 at cycle 0 (wb at 3), add tag 2 offered at cycle 1 → in_ready=0 at cycle 1. Add accepted at cycle 2, wb at 4. Results appear tag 1 @3, tag 2 @4.
- Iterative unit: div tag 4 at cycle 0, second div offered from cycle 1 → in_ready=0 for cycles 1..8. Accepted at cycle 9; writebacks at 8 and 17. A cmp op issued at cycle 2 is accepted and written back at cycle 3.
- Pipelined back-to-back: adds with tags 5,6,7 at cycles 0,1,2 → wb at cycles 2,3,4 in order; inflight=2 at cycles 2 and 3, 1 at cycle 4, 0 at cycle 5.
- Flush: mul at cycle 0, flush at cycle 1 → in_ready=0 at cycle 1; no wb_valid at cycle 3; busy=0 and inflight=0 from cycle 2.
- Reset mid-op: div at cycle 0, rst high at cycle 3 → all outputs 0 at cycle 4. No wb at cycle 8. A div offered at cycle 5 with rst low is accepted.
